user_key_ctrl: RTL and testbench

//  Debounce/event controller for the 8 active-low board user keys; bus slave behind the CPU bridge.

---
 rtl/user_key_ctrl.sv | 124 ++++++++++++
 tb/tb_user_key_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_key_ctrl.sv
// Debounce and event controller for eight active-low user keys, with a small
// register file and a maskable level interrupt request.
module user_key_ctrl #(
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_N   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  user_key,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);

  localparam logic [1:0] ADDR_KEY   = 2'd0;
  localparam logic [1:0] ADDR_EVENT = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;
  localparam logic [1:0] ADDR_RAW   = 2'd3;

  logic [7:0]    sync1_q, sync2_q;
  logic [7:0]    raw_pressed;
  logic [CW-1:0] presc_q, presc_d;
  logic          tick;
  logic [7:0]    key_q, key_d;
  logic [7:0]    event_q, event_d;
  logic [7:0]    mask_q, mask_d;
  logic          ie_q, ie_d;
  logic          irq_d;
  logic [7:0]    press_set;
  logic [7:0]    hist_all1, hist_all0;
  logic          wr_event, wr_ctrl;
  logic          unused_wd;

  assign unused_wd = ^WD[31:16];

  // Synchronisers idle at the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 8'hFF;
      sync2_q <= 8'hFF;
    end else begin
      sync1_q <= user_key;
      sync2_q <= sync1_q;
    end
  end

  assign raw_pressed = ~sync2_q;

  assign tick    = (presc_q == DIV_LAST);
  assign presc_d = tick ? '0 : presc_q + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Per-key sample history; the level decision is taken on the freshly shifted history.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_key
      logic [STABLE_N-1:0] hist_q, hist_d;

      assign hist_d        = {hist_q[STABLE_N-2:0], raw_pressed[gi]};
      assign hist_all1[gi] = &hist_d;
      assign hist_all0[gi] = ~|hist_d;
      assign press_set[gi] = tick & hist_all1[gi] & ~key_q[gi];
      assign key_d[gi]     = !tick        ? key_q[gi] :
                             hist_all1[gi] ? 1'b1 :
                             hist_all0[gi] ? 1'b0 : key_q[gi];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hist_q <= '0;
        end else if (tick) begin
          hist_q <= hist_d;
        end
      end
    end
  endgenerate

  assign wr_event = WE && (Addr == ADDR_EVENT);
  assign wr_ctrl  = WE && (Addr == ADDR_CTRL);

  // A press landing in the same cycle as its W1C clear survives.
  assign event_d = (event_q & ~(wr_event ? WD[7:0] : 8'h00)) | press_set;
  assign mask_d  = wr_ctrl ? WD[15:8] : mask_q;
  assign ie_d    = wr_ctrl ? WD[0] : ie_q;
  assign irq_d   = ie_d & (|(event_d & mask_d));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q   <= 8'h00;
      event_q <= 8'h00;
      mask_q  <= 8'h00;
      ie_q    <= 1'b0;
      IRQ     <= 1'b0;
    end else begin
      key_q   <= key_d;
      event_q <= event_d;
      mask_q  <= mask_d;
      ie_q    <= ie_d;
      IRQ     <= irq_d;
    end
  end

  always_comb begin
    RD = 32'h0;
    case (Addr)
      ADDR_KEY:   RD = {24'h0, key_q};
      ADDR_EVENT: RD = {24'h0, event_q};
      ADDR_CTRL:  RD = {16'h0, mask_q, 7'h0, ie_q};
      ADDR_RAW:   RD = {24'h0, raw_pressed};
      default:    RD = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_user_key_ctrl.sv
// Scenario bench for user_key_ctrl with a fast prescaler (SAMPLE_DIV=4, STABLE_N=4).
module tb_user_key_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  user_key = 8'hFF;
  logic [1:0]  Addr = 2'd0;
  logic        WE = 1'b0;
  logic [31:0] WD = 32'h0;
  logic [31:0] RD;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  user_key_ctrl #(.SAMPLE_DIV(4), .STABLE_N(4)) dut (
    .clk(clk), .reset_n(reset_n), .user_key(user_key),
    .Addr(Addr), .WE(WE), .WD(WD), .RD(RD), .IRQ(IRQ)
  );

  task automatic push_exp(input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a; WD = d; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0; WD = 32'h0;
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = RD;
  endtask

  task automatic wait_key(input logic [7:0] exp, input int budget, output int cycles);
    cycles = -1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      Addr = 2'd0;
      #1;
      if (RD[7:0] === exp) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] d;
    int cyc;
    for (int a = 0; a < 4; a++) push_exp(2'(a), 32'h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read(e.addr, d);
      checks++;
      if (d !== e.data) begin
        errors++;
        $display("FAIL reset_init addr=%0d got=%h exp=%h", e.addr, d, e.data);
      end
    end
    bus_write(2'd2, 32'h0000_FF01);
    user_key = 8'h00;
    wait_key(8'hFF, 40, cyc);
    checks++;
    if (cyc < 0 || IRQ !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload cycles=%0d irq=%b exp irq=1", cyc, IRQ);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq_async got=%b exp=0", IRQ);
    end
    for (int a = 0; a < 4; a++) push_exp(2'(a), 32'h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read(e.addr, d);
      checks++;
      if (d !== e.data) begin
        errors++;
        $display("FAIL reset_async addr=%0d got=%h exp=%h", e.addr, d, e.data);
      end
    end
    user_key = 8'hFF;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_clean_press();
    exp_t e;
    logic [31:0] d;
    int cyc;
    @(negedge clk);
    user_key = 8'hF7;
    push_exp(2'd0, 32'h08);
    push_exp(2'd1, 32'h08);
    push_exp(2'd2, 32'h00);
    push_exp(2'd3, 32'h08);
    wait_key(8'h08, 40, cyc);
    checks++;
    if (cyc < 14 || cyc > 22) begin
      errors++;
      $display("FAIL press_latency got=%0d exp=14..22", cyc);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read(e.addr, d);
      checks++;
      if (d !== e.data) begin
        errors++;
        $display("FAIL press_regs addr=%0d got=%h exp=%h", e.addr, d, e.data);
      end
    end
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL press_irq got=%b exp=0", IRQ);
    end
    user_key = 8'hFF;
    wait_key(8'h00, 40, cyc);
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL press_release got=timeout exp=KEY 00");
    end
    bus_write(2'd1, 32'hFF);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL press_w1c got=%h exp=00000000", d);
    end
    $display("clean_press: latency=%0d", cyc);
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    int seen = 0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (c < 60 && c % 5 == 0) user_key[0] = ~user_key[0];
      if (c == 60) user_key = 8'hFF;
      Addr = 2'd0;
      #1;
      if (RD[0] === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL bounce_key0 got=%0d cycles pressed exp=0", seen);
    end
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL bounce_event got=%h exp=00000000", d);
    end
    $display("bounce: key0 pressed cycles=%0d", seen);
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic prev_irq = 1'b0;
    logic hit = 1'b0;
    int cyc;
    bus_write(2'd2, 32'h0000_0101);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0000_0101) begin
      errors++;
      $display("FAIL irq_ctrl_rd got=%h exp=00000101", d);
    end
    user_key = 8'hFE;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      Addr = 2'd1;
      #1;
      if (RD[0] === 1'b1) begin
        hit = 1'b1;
        break;
      end
      prev_irq = IRQ;
    end
    checks++;
    if (!hit || IRQ !== 1'b1 || prev_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_assert hit=%b irq=%b prev=%b exp 1/1/0", hit, IRQ, prev_irq);
    end
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h0 || IRQ !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear event=%h irq=%b exp 00000000/0", d, IRQ);
    end
    user_key = 8'hFF;
    wait_key(8'h00, 40, cyc);
    user_key = 8'hFD;
    wait_key(8'h02, 40, cyc);
    bus_read(2'd1, d);
    checks++;
    if (cyc < 0 || d !== 32'h02 || IRQ !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked cycles=%0d event=%h irq=%b exp 02/0", cyc, d, IRQ);
    end
    bus_write(2'd2, 32'h0000_0201);
    checks++;
    if (IRQ !== 1'b1) begin
      errors++;
      $display("FAIL irq_mask_write got=%b exp=1", IRQ);
    end
    user_key = 8'hFF;
    wait_key(8'h00, 40, cyc);
    $display("irq: done");
  endtask

  task automatic test_race();
    logic hit = 1'b0;
    int cyc;
    bus_write(2'd2, 32'h0000_0401);
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL race_mask_off got=%b exp=0", IRQ);
    end
    @(negedge clk);
    Addr = 2'd1; WD = 32'h4; WE = 1'b1;
    user_key = 8'hFB;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (RD[2] === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit || RD[7:0] !== 8'h06 || IRQ !== 1'b1) begin
      errors++;
      $display("FAIL race_set_wins hit=%b event=%h irq=%b exp 1/06/1", hit, RD[7:0], IRQ);
    end
    @(negedge clk);
    #1;
    checks++;
    if (RD[7:0] !== 8'h02 || IRQ !== 1'b0) begin
      errors++;
      $display("FAIL race_later_clear event=%h irq=%b exp 02/0", RD[7:0], IRQ);
    end
    WE = 1'b0; WD = 32'h0;
    user_key = 8'hFF;
    wait_key(8'h00, 40, cyc);
    bus_write(2'd1, 32'hFF);
    bus_write(2'd2, 32'h0);
    $display("race: hit=%b", hit);
  endtask

  task automatic test_release_wrap();
    exp_t e;
    logic [31:0] d;
    int cyc;
    int ticks = 0;
    @(negedge clk);
    user_key = 8'h00;
    push_exp(2'd1, 32'hFF);
    wait_key(8'hFF, 40, cyc);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read(e.addr, d);
      checks++;
      if (cyc < 0 || d !== e.data) begin
        errors++;
        $display("FAIL all_press cycles=%0d addr=%0d got=%h exp=%h", cyc, e.addr, d, e.data);
      end
    end
    bus_write(2'd1, 32'hFF);
    @(negedge clk);
    user_key = 8'hFF;
    push_exp(2'd1, 32'h00);
    wait_key(8'h00, 40, cyc);
    checks++;
    if (cyc < 14 || cyc > 22) begin
      errors++;
      $display("FAIL release_latency got=%0d exp=14..22", cyc);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read(e.addr, d);
      checks++;
      if (d !== e.data) begin
        errors++;
        $display("FAIL release_no_event addr=%0d got=%h exp=%h", e.addr, d, e.data);
      end
    end
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (dut.tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks !== 25) begin
      errors++;
      $display("FAIL tick_wrap got=%0d exp=25", ticks);
    end
    $display("release_wrap: release latency=%0d ticks=%0d", cyc, ticks);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_irq();
    test_race();
    test_release_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
